// File: rtl/gxsim_qspi_target.sv
`default_nettype none
//==============================================================================
// Module   : gxsim_qspi_target
// Purpose  : Oversampled quad-SPI target that turns manager read/write bursts
//            into register accesses and serialises read data back to the bus.
// Revision : 1.0 - initial release
//==============================================================================
module gxsim_qspi_target #(
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] CMD_WRITE    = 8'h02,
    parameter logic [7:0] CMD_READ     = 8'h0B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        qspi_sck,
    input  logic        qspi_cs_n,
    input  logic [3:0]  qspi_dq_in,
    output logic [3:0]  qspi_dq_out,
    output logic        qspi_dq_oe,
    output logic [31:0] address,
    output logic [31:0] wdata,
    output logic        write_strobe,
    input  logic [31:0] rdata,
    output logic [15:0] bad_cmd_count
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD    = 3'd1;
    localparam logic [2:0] c_ST_ADDR   = 3'd2;
    localparam logic [2:0] c_ST_WDATA  = 3'd3;
    localparam logic [2:0] c_ST_DUMMY  = 3'd4;
    localparam logic [2:0] c_ST_RDATA  = 3'd5;
    localparam logic [2:0] c_ST_IGNORE = 3'd6;

    localparam int c_DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DUMMY_LAST = c_DW'(DUMMY_CYCLES - 1);

    logic [2:0]      r_state, w_state_next;
    logic            r_sck_meta, r_sck_sync, r_sck_prev;
    logic            r_cs_meta, r_cs_sync, r_cs_prev;
    logic [3:0]      r_dq_meta, r_dq_sync;
    logic [2:0]      r_nib_cnt;
    logic [c_DW-1:0] r_dummy_cnt;
    logic [27:0]     r_shift;
    logic [31:0]     r_tx_shift;
    logic [31:0]     r_address;
    logic [31:0]     r_wdata;
    logic            r_is_read;
    logic            r_write_strobe;
    logic            r_dq_oe;
    logic [15:0]     r_bad_cmd_count;

    logic            w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic            w_rise, w_fall, w_last_nib, w_cmd_ok;
    logic [31:0]     w_nib_in;

    // CS synchroniser resets low so a CS already held low after reset is
    // never mistaken for a fresh fall; only a high-then-low sequence starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_cs_meta  <= 1'b0;
            r_cs_sync  <= 1'b0;
            r_cs_prev  <= 1'b0;
            r_dq_meta  <= 4'h0;
            r_dq_sync  <= 4'h0;
        end else begin
            r_sck_meta <= qspi_sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_cs_meta  <= qspi_cs_n;
            r_cs_sync  <= r_cs_meta;
            r_cs_prev  <= r_cs_sync;
            r_dq_meta  <= qspi_dq_in;
            r_dq_sync  <= r_dq_meta;
        end
    end

    assign w_sck_rise = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync & r_sck_prev;
    assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
    assign w_cs_fall  = ~r_cs_sync & r_cs_prev;
    assign w_rise     = w_sck_rise & ~w_cs_rise;
    assign w_fall     = w_sck_fall & ~w_cs_rise;
    assign w_nib_in   = {r_shift, r_dq_sync};
    assign w_last_nib = (r_nib_cnt == 3'd7);
    assign w_cmd_ok   = (w_nib_in[7:0] == CMD_WRITE) || (w_nib_in[7:0] == CMD_READ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_cs_fall) w_state_next = c_ST_CMD;
                end
                c_ST_CMD: begin
                    if (w_rise && r_nib_cnt == 3'd1)
                        w_state_next = w_cmd_ok ? c_ST_ADDR : c_ST_IGNORE;
                end
                c_ST_ADDR: begin
                    if (w_rise && w_last_nib)
                        w_state_next = r_is_read ? c_ST_DUMMY : c_ST_WDATA;
                end
                c_ST_DUMMY: begin
                    if (w_rise && r_dummy_cnt == c_DUMMY_LAST) w_state_next = c_ST_RDATA;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nib_cnt       <= 3'd0;
            r_dummy_cnt     <= '0;
            r_shift         <= 28'h0;
            r_tx_shift      <= 32'h0;
            r_address       <= 32'h0;
            r_wdata         <= 32'h0;
            r_is_read       <= 1'b0;
            r_write_strobe  <= 1'b0;
            r_dq_oe         <= 1'b0;
            r_bad_cmd_count <= 16'h0;
        end else begin
            r_write_strobe <= 1'b0;
            r_dq_oe        <= (w_state_next == c_ST_RDATA);
            // Post-strobe increment; an address load later in this block wins.
            if (r_write_strobe) r_address <= r_address + 32'd4;
            if (w_cs_rise) r_tx_shift <= 32'h0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_nib_cnt   <= 3'd0;
                        r_dummy_cnt <= '0;
                    end
                end
                c_ST_CMD: begin
                    if (w_rise) begin
                        r_shift   <= w_nib_in[27:0];
                        r_nib_cnt <= (r_nib_cnt == 3'd1) ? 3'd0 : r_nib_cnt + 3'd1;
                        if (r_nib_cnt == 3'd1) begin
                            r_is_read <= (w_nib_in[7:0] == CMD_READ);
                            if (!w_cmd_ok && r_bad_cmd_count != 16'hFFFF)
                                r_bad_cmd_count <= r_bad_cmd_count + 16'd1;
                        end
                    end
                end
                c_ST_ADDR: begin
                    if (w_rise) begin
                        r_shift   <= w_nib_in[27:0];
                        r_nib_cnt <= r_nib_cnt + 3'd1;
                        if (w_last_nib) r_address <= w_nib_in;
                    end
                end
                c_ST_WDATA: begin
                    if (w_rise) begin
                        r_shift   <= w_nib_in[27:0];
                        r_nib_cnt <= r_nib_cnt + 3'd1;
                        if (w_last_nib) begin
                            r_wdata        <= w_nib_in;
                            r_write_strobe <= 1'b1;
                        end
                    end
                end
                c_ST_DUMMY: begin
                    if (w_rise) r_dummy_cnt <= r_dummy_cnt + 1'b1;
                end
                c_ST_RDATA: begin
                    if (w_rise) begin
                        r_nib_cnt <= r_nib_cnt + 3'd1;
                        if (w_last_nib) r_address <= r_address + 32'd4;
                    end
                    // Word boundary reloads from rdata, which already reflects
                    // the address advanced on the preceding rise.
                    if (w_fall) begin
                        if (r_nib_cnt == 3'd0) r_tx_shift <= rdata;
                        else                   r_tx_shift <= {r_tx_shift[27:0], 4'h0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign qspi_dq_out   = r_tx_shift[31:28];
    assign qspi_dq_oe    = r_dq_oe;
    assign address       = r_address;
    assign wdata         = r_wdata;
    assign write_strobe  = r_write_strobe;
    assign bad_cmd_count = r_bad_cmd_count;

endmodule
`default_nettype wire
